// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: state encoding, error codes and
// frame layout constants.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StWrite,
        StChk,
        StDone,
        StErr
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_LENGTH   = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_ABORTED  = 2'd3;

    localparam int unsigned HDR_LEN        = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Byte address of word k relative to the load base, kept wide enough that 4*k never wraps.
    function automatic logic [17:0] word_byte_offset(input logic [15:0] k);
        return {k, 2'b00};
    endfunction

endpackage

// File: rtl/inst_loader_byte_to_word.sv
// Assembles a little-endian 32-bit word from a byte stream; flags the byte that completes it.
module inst_loader_byte_to_word
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_last
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_clear) begin
            r_cnt  <= 2'd0;
        end else if (i_en) begin
            // Shift in from the top so the first byte ends up in bits [7:0].
            r_word <= {i_byte, r_word[31:8]};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    assign o_word = r_word;
    assign o_last = i_en && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses a framed byte stream and writes 32-bit words into instruction memory,
// stalling the core until the program has loaded with a good checksum.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               inst_store,
    output logic [WIDTH+23:0]  addr,
    output logic [WIDTH+23:0]  data_in,
    output logic               busy,
    output logic               cpu_stall,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam int unsigned AW        = WIDTH + 24;
    localparam logic [17:0] MAX_BYTES = 18'(DEPTH - BASE_ADDR);

    state_e      r_state, w_state_nxt;
    logic [15:0] r_n, w_n_nxt;
    logic [15:0] r_k, w_k_nxt;
    logic        r_hdr_idx, w_hdr_idx_nxt;
    logic [7:0]  r_chk, w_chk_nxt;
    logic [1:0]  r_err_code, w_err_code_nxt;

    logic        w_accept;
    logic        w_word_en;
    logic        w_word_clr;
    logic        w_word_last;
    logic [31:0] w_word;
    logic [15:0] w_n_hdr;
    logic [15:0] w_k_inc;
    logic        w_active_in;

    assign w_active_in = (r_state == StHdr) || (r_state == StData) || (r_state == StChk);
    assign in_ready    = w_active_in && !abort;
    assign w_accept    = in_valid && in_ready;
    assign w_word_en   = w_accept && (r_state == StData);
    assign w_n_hdr     = {in_data, r_n[7:0]};
    assign w_k_inc     = r_k + 16'd1;

    inst_loader_byte_to_word u_byte_to_word (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_word_clr),
        .i_en    (w_word_en),
        .i_byte  (in_data),
        .o_word  (w_word),
        .o_last  (w_word_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_n        <= 16'd0;
            r_k        <= 16'd0;
            r_hdr_idx  <= 1'b0;
            r_chk      <= 8'd0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_n        <= w_n_nxt;
            r_k        <= w_k_nxt;
            r_hdr_idx  <= w_hdr_idx_nxt;
            r_chk      <= w_chk_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_n_nxt        = r_n;
        w_k_nxt        = r_k;
        w_hdr_idx_nxt  = r_hdr_idx;
        w_chk_nxt      = r_chk;
        w_err_code_nxt = r_err_code;
        w_word_clr     = 1'b0;

        unique case (r_state)
            StIdle, StDone, StErr: begin
                if (start) begin
                    w_state_nxt    = StHdr;
                    w_n_nxt        = 16'd0;
                    w_k_nxt        = 16'd0;
                    w_hdr_idx_nxt  = 1'b0;
                    w_chk_nxt      = 8'd0;
                    w_err_code_nxt = ERR_NONE;
                    w_word_clr     = 1'b1;
                end
            end
            StHdr: begin
                if (abort) begin
                    w_state_nxt    = StErr;
                    w_err_code_nxt = ERR_ABORTED;
                end else if (w_accept) begin
                    if (r_hdr_idx != 1'(HDR_LEN - 1)) begin
                        w_n_nxt[7:0]  = in_data;
                        w_hdr_idx_nxt = 1'b1;
                    end else begin
                        w_n_nxt = w_n_hdr;
                        // Length compared at 18 bits so a large N cannot wrap past the limit.
                        if (word_byte_offset(w_n_hdr) > MAX_BYTES) begin
                            w_state_nxt    = StErr;
                            w_err_code_nxt = ERR_LENGTH;
                        end else if (w_n_hdr == 16'd0) begin
                            w_state_nxt = StChk;
                        end else begin
                            w_state_nxt = StData;
                        end
                    end
                end
            end
            StData: begin
                if (abort) begin
                    w_state_nxt    = StErr;
                    w_err_code_nxt = ERR_ABORTED;
                end else if (w_accept) begin
                    w_chk_nxt = r_chk ^ in_data;
                    if (w_word_last) begin
                        w_state_nxt = StWrite;
                    end
                end
            end
            StWrite: begin
                if (abort) begin
                    w_state_nxt    = StErr;
                    w_err_code_nxt = ERR_ABORTED;
                end else begin
                    w_k_nxt     = w_k_inc;
                    w_state_nxt = (w_k_inc == r_n) ? StChk : StData;
                end
            end
            StChk: begin
                if (abort) begin
                    w_state_nxt    = StErr;
                    w_err_code_nxt = ERR_ABORTED;
                end else if (w_accept) begin
                    if (in_data == r_chk) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt    = StErr;
                        w_err_code_nxt = ERR_CHECKSUM;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        busy       = (r_state == StHdr) || (r_state == StData) ||
                     (r_state == StWrite) || (r_state == StChk);
        done       = (r_state == StDone);
        err        = (r_state == StErr);
        cpu_stall  = busy || err;
        err_code   = r_err_code;
        // Abort suppresses a pending write in the same cycle.
        inst_store = (r_state == StWrite) && !abort;
        addr       = '0;
        data_in    = '0;
        if (inst_store) begin
            addr    = AW'(BASE_ADDR) + AW'(word_byte_offset(r_k));
            data_in = AW'(w_word);
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected writes are queued as frames are sent and matched
// against every inst_store strobe.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        inst_store;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        busy;
    logic        cpu_stall;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_stores = 0;
    logic [63:0] sb_q[$];

    inst_loader #(
        .WIDTH     (8),
        .DEPTH     (32),
        .BASE_ADDR (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .inst_store (inst_store),
        .addr       (addr),
        .data_in    (data_in),
        .busy       (busy),
        .cpu_stall  (cpu_stall),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && inst_store) begin
            n_stores++;
            if (sb_q.size() == 0) begin
                check("unexpected_store", {addr, data_in}, 64'd0);
            end else begin
                logic [63:0] exp_w;
                exp_w = sb_q.pop_front();
                check("store_addr", 64'(addr), 64'(exp_w[63:32]));
                check("store_data", 64'(data_in), 64'(exp_w[31:0]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) check("ready_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int max_gap);
        foreach (bytes[i]) send_byte(bytes[i], (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
    endtask

    task automatic wait_end();
        int budget;
        budget = 0;
        while (!(done || err) && budget < 300) begin
            tick();
            budget++;
        end
        if (budget >= 300) check("end_timeout", {63'd0, done | err}, 64'd1);
    endtask

    task automatic check_done(input string tag, input int stores_before, input int exp_writes);
        check({tag, "_done"}, {60'd0, done, err, err_code}, {60'd0, 1'b1, 1'b0, 2'd0});
        check({tag, "_stall"}, {62'd0, busy, cpu_stall}, 64'd0);
        check({tag, "_nwrites"}, 64'(n_stores - stores_before), 64'(exp_writes));
        check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    logic [7:0] f1[$]    = '{8'h01, 8'h00, 8'h13, 8'h02, 8'hA0, 8'h00, 8'hB1};
    logic [7:0] f2[$]    = '{8'h02, 8'h00, 8'h13, 8'h02, 8'hA0, 8'h00,
                             8'h93, 8'h02, 8'hF0, 8'h00, 8'hD0};
    logic [7:0] f_bad[$] = '{8'h01, 8'h00, 8'h13, 8'h02, 8'hA0, 8'h00, 8'h00};
    logic [7:0] f_big[$] = '{8'h09, 8'h00};
    logic [7:0] f_abt[$] = '{8'h01, 8'h00, 8'h13, 8'h02};
    logic [7:0] f_zero[$] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] f_rst[$] = '{8'h01, 8'h00, 8'h13};

    initial begin
        int s0;
        #3;
        check("reset_ctrl", {56'd0, in_ready, inst_store, busy, cpu_stall, done, err, err_code},
              64'd0);
        check("reset_bus", {addr, data_in}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        check("idle_ready", {62'd0, in_ready, busy}, 64'd0);

        // Single-word program
        s0 = n_stores;
        pulse_start();
        check("t1_busy", {62'd0, busy, cpu_stall}, 64'h3);
        sb_q.push_back({32'h0, 32'h00A00213});
        send_frame(f1, 0);
        wait_end();
        check_done("t1", s0, 1);

        // Two words
        s0 = n_stores;
        pulse_start();
        sb_q.push_back({32'h0, 32'h00A00213});
        sb_q.push_back({32'h4, 32'h00F00293});
        send_frame(f2, 0);
        wait_end();
        check_done("t2", s0, 2);

        // Length overflow: 9 words exceed 32 bytes
        s0 = n_stores;
        pulse_start();
        send_frame(f_big, 0);
        check("ovf_err", {60'd0, err, done, err_code}, {60'd0, 1'b1, 1'b0, 2'd1});
        check("ovf_ready", {61'd0, in_ready, busy, cpu_stall}, 64'h1);
        repeat (3) tick();
        check("ovf_nwrites", 64'(n_stores - s0), 64'd0);

        // Bad checksum: write still happens
        s0 = n_stores;
        pulse_start();
        check("restart_clears", {60'd0, err, done, err_code}, 64'd0);
        sb_q.push_back({32'h0, 32'h00A00213});
        send_frame(f_bad, 0);
        wait_end();
        check("chk_err", {60'd0, err, done, err_code}, {60'd0, 1'b1, 1'b0, 2'd2});
        check("chk_stall", {62'd0, busy, cpu_stall}, 64'h1);
        check("chk_nwrites", 64'(n_stores - s0), 64'd1);

        // Abort after two data bytes, then a good reload
        s0 = n_stores;
        pulse_start();
        send_frame(f_abt, 0);
        abort = 1'b1;
        #1;
        check("abort_ready", 64'(in_ready), 64'd0);
        tick();
        abort = 1'b0;
        check("abort_err", {60'd0, err, done, err_code}, {60'd0, 1'b1, 1'b0, 2'd3});
        check("abort_nwrites", 64'(n_stores - s0), 64'd0);
        pulse_start();
        sb_q.push_back({32'h0, 32'h00A00213});
        send_frame(f1, 0);
        wait_end();
        check_done("reload", s0, 1);

        // Empty program
        s0 = n_stores;
        pulse_start();
        send_frame(f_zero, 0);
        wait_end();
        check_done("n0", s0, 0);

        // Two words with random valid gaps and a spurious start while busy
        s0 = n_stores;
        pulse_start();
        pulse_start();
        sb_q.push_back({32'h0, 32'h00A00213});
        sb_q.push_back({32'h4, 32'h00F00293});
        send_frame(f2, 3);
        wait_end();
        check_done("gaps", s0, 2);

        // Reset mid-DATA
        pulse_start();
        send_frame(f_rst, 0);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ctrl",
              {56'd0, in_ready, inst_store, busy, cpu_stall, done, err, err_code}, 64'd0);
        check("mid_rst_bus", {addr, data_in}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_idle", {60'd0, in_ready, busy, cpu_stall, done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
